// File: rtl/alarm_sequencer.sv
// Alarm clock ring/snooze sequencer: IDLE -> RINGING <-> SNOOZE -> DONE.
// Optional macro ALARM_SNOOZE_LIMIT_EN caps snoozes per episode at MAX_SNOOZE.
module alarm_sequencer #(
   parameter logic [7:0] RING_SECONDS   = 8'd60,
   parameter logic [7:0] SNOOZE_SECONDS = 8'd120,
   parameter logic [2:0] MAX_SNOOZE     = 3'd3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        one_second,
   input  logic        alarm_enable,
   input  logic [15:0] current_time,
   input  logic [15:0] alarm_time,
   input  logic        stop_button,
   input  logic        snooze_button,
   output logic        sound_alarm,
   output logic        snooze_active,
   output logic        alarm_event,
   output logic [2:0]  snooze_count
);

   typedef enum logic [1:0] {
      IDLE,
      RINGING,
      SNOOZE,
      DONE
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] ring_q, ring_d;
   logic [7:0] snz_q, snz_d;
   logic [2:0] cnt_q, cnt_d;
   logic       event_q;
   logic       match;
   logic       limit_hit;

   assign match = alarm_enable && (current_time == alarm_time);

`ifdef ALARM_SNOOZE_LIMIT_EN
   assign limit_hit = (cnt_q == MAX_SNOOZE);
`else
   logic unused_max_snooze;
   assign limit_hit         = 1'b0;
   assign unused_max_snooze = ^MAX_SNOOZE;
`endif

   // Next-state, timer and snooze-count logic
   always_comb begin
      state_d = state_q;
      ring_d  = ring_q;
      snz_d   = snz_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (match) begin
               state_d = RINGING;
               ring_d  = '0;
            end
         end
         RINGING: begin
            if (!alarm_enable) begin
               state_d = DONE;
            end else if (stop_button) begin
               state_d = DONE;
            end else if (snooze_button && !limit_hit) begin
               state_d = SNOOZE;
               snz_d   = '0;
               if (cnt_q != 3'd7)
                  cnt_d = cnt_q + 3'd1;
            end else if (one_second) begin
               if (ring_q == RING_SECONDS - 8'd1)
                  state_d = DONE;
               else if (ring_q != 8'hFF)
                  ring_d = ring_q + 8'd1;
            end
         end
         SNOOZE: begin
            if (!alarm_enable) begin
               state_d = DONE;
            end else if (stop_button) begin
               state_d = DONE;
            end else if (one_second) begin
               if (snz_q == SNOOZE_SECONDS - 8'd1) begin
                  state_d = RINGING;
                  ring_d  = '0;
               end else if (snz_q != 8'hFF) begin
                  snz_d = snz_q + 8'd1;
               end
            end
         end
         DONE: begin
            if (!match) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, timers, count and the ring-entry pulse
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ring_q  <= '0;
         snz_q   <= '0;
         cnt_q   <= '0;
         event_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ring_q  <= ring_d;
         snz_q   <= snz_d;
         cnt_q   <= cnt_d;
         event_q <= (state_d == RINGING) && (state_q != RINGING);
      end
   end

   assign sound_alarm   = (state_q == RINGING);
   assign snooze_active = (state_q == SNOOZE);
   assign alarm_event   = event_q;
   assign snooze_count  = cnt_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer: stimulus queues expected
// outputs tagged by cycle, a negedge monitor pops and compares.
module tb_alarm_sequencer;

   logic        clock;
   logic        reset;
   logic        one_second;
   logic        alarm_enable;
   logic [15:0] current_time;
   logic [15:0] alarm_time;
   logic        stop_button;
   logic        snooze_button;
   logic        sound_alarm;
   logic        snooze_active;
   logic        alarm_event;
   logic [2:0]  snooze_count;

   alarm_sequencer dut (
      .clock         (clock),
      .reset         (reset),
      .one_second    (one_second),
      .alarm_enable  (alarm_enable),
      .current_time  (current_time),
      .alarm_time    (alarm_time),
      .stop_button   (stop_button),
      .snooze_button (snooze_button),
      .sound_alarm   (sound_alarm),
      .snooze_active (snooze_active),
      .alarm_event   (alarm_event),
      .snooze_count  (snooze_count)
   );

   typedef struct {
      int         cyc;
      string      nm;
      logic       s;
      logic       z;
      logic       e;
      logic [2:0] c;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   nchecks = 0;
   int   nfail  = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic expect_out(input string nm, input int dly,
                             input logic s, input logic z,
                             input logic e, input logic [2:0] c);
      exp_t x;
      x.cyc = cyc + dly;
      x.nm  = nm;
      x.s   = s;
      x.z   = z;
      x.e   = e;
      x.c   = c;
      sb.push_back(x);
   endtask

   always @(negedge clock) begin
      int i;
      exp_t x;
      i = 0;
      while (i < sb.size()) begin
         x = sb[i];
         if (x.cyc <= cyc) begin
            sb.delete(i);
            nchecks++;
            if (x.cyc < cyc ||
                sound_alarm !== x.s || snooze_active !== x.z ||
                alarm_event !== x.e || snooze_count !== x.c) begin
               nfail++;
               $display("FAIL %s @%0d: got s=%b z=%b e=%b c=%0d want s=%b z=%b e=%b c=%0d",
                        x.nm, cyc, sound_alarm, snooze_active,
                        alarm_event, snooze_count, x.s, x.z, x.e, x.c);
            end
         end else begin
            i++;
         end
      end
   end

`ifdef ALARM_SNOOZE_LIMIT_EN
   localparam logic       FOURTH_S = 1'b1;
   localparam logic       FOURTH_Z = 1'b0;
   localparam logic [2:0] FOURTH_C = 3'd3;
`else
   localparam logic       FOURTH_S = 1'b0;
   localparam logic       FOURTH_Z = 1'b1;
   localparam logic [2:0] FOURTH_C = 3'd4;
`endif

   initial begin
      reset         = 1'b0;
      one_second    = 1'b0;
      alarm_enable  = 1'b1;
      current_time  = 16'h0729;
      alarm_time    = 16'h0730;
      stop_button   = 1'b0;
      snooze_button = 1'b0;
      step(2);
      nchecks++;
      if (sound_alarm !== 1'b0 || snooze_count !== 3'd0) begin
         nfail++;
         $display("FAIL direct_reset: s=%b c=%0d", sound_alarm, snooze_count);
      end
      expect_out("reset_state", 0, 0, 0, 0, 3'd0);
      step(1);
      reset = 1'b1;
      step(2);
      expect_out("no_match_0729", 0, 0, 0, 0, 3'd0);
      step(1);

      current_time = 16'h0730;
      expect_out("trigger", 1, 1, 0, 1, 3'd0);
      expect_out("event_one_cycle", 2, 1, 0, 0, 3'd0);
      step(2);
      nchecks++;
      if (sound_alarm !== 1'b1 || alarm_event !== 1'b0) begin
         nfail++;
         $display("FAIL direct_ring: s=%b e=%b", sound_alarm, alarm_event);
      end
      one_second = 1'b1;
      expect_out("ring_59", 59, 1, 0, 0, 3'd0);
      expect_out("ring_timeout", 60, 0, 0, 0, 3'd0);
      step(60);
      one_second = 1'b0;
      step(3);
      nchecks++;
      if (sound_alarm !== 1'b0) begin
         nfail++;
         $display("FAIL direct_timeout: s=%b", sound_alarm);
      end
      expect_out("done_hold", 0, 0, 0, 0, 3'd0);
      step(1);
      current_time = 16'h0731;
      step(2);
      current_time = 16'h0730;
      expect_out("retrigger", 1, 1, 0, 1, 3'd0);
      step(2);

      one_second = 1'b1;
      step(30);
      one_second = 1'b0;
      expect_out("ring_mid", 0, 1, 0, 0, 3'd0);
      step(1);
      snooze_button = 1'b1;
      expect_out("snooze_enter", 1, 0, 1, 0, 3'd1);
      step(1);
      nchecks++;
      if (snooze_active !== 1'b1 || snooze_count !== 3'd1) begin
         nfail++;
         $display("FAIL direct_snooze: z=%b c=%0d", snooze_active, snooze_count);
      end
      snooze_button = 1'b0;
      one_second = 1'b1;
      expect_out("snooze_119", 119, 0, 1, 0, 3'd1);
      expect_out("snooze_expire", 120, 1, 0, 1, 3'd1);
      step(120);
      one_second = 1'b0;
      expect_out("ring_after_snooze", 1, 1, 0, 0, 3'd1);
      step(1);
      one_second = 1'b1;
      expect_out("ring2_59", 59, 1, 0, 0, 3'd1);
      expect_out("ring2_timeout", 60, 0, 0, 0, 3'd1);
      step(60);
      one_second = 1'b0;
      current_time = 16'h0731;
      expect_out("count_clear", 1, 0, 0, 0, 3'd0);
      step(1);

      current_time = 16'h0730;
      expect_out("trig3", 1, 1, 0, 1, 3'd0);
      step(2);
      snooze_button = 1'b1;
      expect_out("snooze2", 1, 0, 1, 0, 3'd1);
      step(1);
      snooze_button = 1'b0;
      one_second = 1'b1;
      step(120);
      one_second = 1'b0;
      expect_out("ring3", 0, 1, 0, 1, 3'd1);
      step(1);
      stop_button   = 1'b1;
      snooze_button = 1'b1;
      expect_out("stop_snooze", 1, 0, 0, 0, 3'd1);
      step(1);
      stop_button   = 1'b0;
      snooze_button = 1'b0;
      step(3);
      expect_out("no_retrigger", 0, 0, 0, 0, 3'd1);
      step(1);
      current_time = 16'h0731;
      expect_out("clear2", 1, 0, 0, 0, 3'd0);
      step(1);

      current_time = 16'h0730;
      expect_out("trig4", 1, 1, 0, 1, 3'd0);
      step(2);
      for (int i = 1; i <= 3; i++) begin
         snooze_button = 1'b1;
         expect_out("lim_snooze", 1, 0, 1, 0, 3'(i));
         step(1);
         snooze_button = 1'b0;
         one_second = 1'b1;
         expect_out("lim_ring", 120, 1, 0, 1, 3'(i));
         step(120);
         one_second = 1'b0;
         step(1);
      end
      snooze_button = 1'b1;
      expect_out("fourth_press", 1, FOURTH_S, FOURTH_Z, 0, FOURTH_C);
      step(1);
      snooze_button = 1'b0;
      stop_button = 1'b1;
      expect_out("fourth_done", 1, 0, 0, 0, FOURTH_C);
      step(1);
      stop_button = 1'b0;
      current_time = 16'h0731;
      step(2);

      current_time = 16'h0730;
      expect_out("trig5", 1, 1, 0, 1, 3'd0);
      step(2);
      snooze_button = 1'b1;
      expect_out("snooze5", 1, 0, 1, 0, 3'd1);
      step(1);
      snooze_button = 1'b0;
      one_second = 1'b1;
      step(5);
      one_second = 1'b0;
      reset = 1'b0;
      #1;
      nchecks++;
      if (snooze_active !== 1'b0) begin
         nfail++;
         $display("FAIL direct_reset_async: z=%b", snooze_active);
      end
      expect_out("reset_async", 0, 0, 0, 0, 3'd0);
      step(2);
      expect_out("reset_hold", 0, 0, 0, 0, 3'd0);
      step(1);
      reset = 1'b1;
      expect_out("reset_retrigger", 1, 1, 0, 1, 3'd0);
      expect_out("reset_event_end", 2, 1, 0, 0, 3'd0);
      step(2);

      current_time = 16'h0731;
      expect_out("time_change_ring", 1, 1, 0, 0, 3'd0);
      step(1);
      current_time = 16'h0730;
      alarm_enable = 1'b0;
      expect_out("disable_stop", 1, 0, 0, 0, 3'd0);
      step(1);
      alarm_enable = 1'b1;
      expect_out("reenable_1", 1, 0, 0, 0, 3'd0);
      expect_out("reenable_3", 3, 0, 0, 0, 3'd0);
      step(3);
      current_time = 16'h0800;
      step(2);
      alarm_enable = 1'b0;
      current_time = 16'h0730;
      expect_out("disabled_match", 1, 0, 0, 0, 3'd0);
      step(2);
      current_time = 16'h1730;
      alarm_enable = 1'b1;
      expect_out("digit_diff", 1, 0, 0, 0, 3'd0);
      step(2);
      current_time = 16'h0730;
      expect_out("enable_trig", 1, 1, 0, 1, 3'd0);
      step(2);

      for (int i = 0; i < 20 && sb.size() > 0; i++)
         step(1);
      while (sb.size() > 0) begin
         nchecks++;
         nfail++;
         $display("FAIL %s: never checked, due cycle %0d now %0d",
                  sb[0].nm, sb[0].cyc, cyc);
         void'(sb.pop_front());
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchecks, nfail);
      $finish;
   end

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 The block SHALL have parameter RING_SECONDS, default 8'd60, giving the maximum ring duration in one_second pulses (legal 1..255).
REQ-002 The block SHALL have parameter SNOOZE_SECONDS, default 8'd120, giving the snooze duration in one_second pulses (legal 1..255).
REQ-003 The block SHALL have parameter MAX_SNOOZE, default 3'd3, giving the snooze limit used only under ALARM_SNOOZE_LIMIT_EN (legal 1..7).
REQ-004 clock  in  1  single system clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 one_second  in  1  one-cycle tick, once per second.
REQ-007 alarm_enable  in  1  alarm armed switch, level.
REQ-008 current_time  in  16  current HH:MM as four BCD digits.
REQ-009 alarm_time  in  16  stored alarm HH:MM as four BCD digits.
REQ-010 stop_button  in  1  stop request, level, sampled every cycle.
REQ-011 snooze_button  in  1  snooze request, level, sampled every cycle.
REQ-012 sound_alarm  out  1  high while ringing.
REQ-013 snooze_active  out  1  high while snoozing.
REQ-014 alarm_event  out  1  one-cycle pulse on every entry to RINGING.
REQ-015 snooze_count  out  3  number of snoozes taken in the current alarm episode.

Function
REQ-016 match SHALL equal alarm_enable AND (current_time == alarm_time), combinational, full 16-bit compare.
REQ-017 States SHALL be IDLE, RINGING, SNOOZE, DONE; transitions occur one clock after the condition is sampled.
REQ-018 IDLE: match -> RINGING, clearing ring_timer; otherwise hold.
REQ-019 RINGING priority: !alarm_enable -> DONE; else stop_button -> DONE; else snooze_button (and limit not reached) -> SNOOZE, clearing snooze_timer, snooze_count+1; else one_second with ring_timer == RING_SECONDS-1 -> DONE; else one_second increments ring_timer.
REQ-020 SNOOZE priority: !alarm_enable -> DONE; else stop_button -> DONE; else one_second with snooze_timer == SNOOZE_SECONDS-1 -> RINGING, clearing ring_timer; else one_second increments snooze_timer.
REQ-021 DONE: !match -> IDLE; otherwise hold, so one alarm minute triggers at most one episode.
REQ-022 snooze_count SHALL clear on the DONE->IDLE transition and saturate at 7.
REQ-023 sound_alarm = (state==RINGING); snooze_active = (state==SNOOZE); both decoded from the state register, no combinational path from inputs.
REQ-024 alarm_event SHALL be a registered pulse, high exactly in the first cycle of each RINGING residency (initial trigger and every snooze expiry).
REQ-025 Timers SHALL be 8 bits and never wrap; they only advance on one_second in their own state.
REQ-026 Simultaneous stop_button and snooze_button SHALL resolve as stop.
REQ-027 alarm_time or current_time changing mid-episode SHALL NOT affect RINGING/SNOOZE; only DONE consults match.

Reset
REQ-028 reset low SHALL asynchronously force state IDLE, both timers 0, snooze_count 0, and all outputs 0.
REQ-029 Reset asserted mid-RINGING or mid-SNOOZE SHALL abandon the episode; after release, a still-true match SHALL retrigger RINGING.

Configuration
REQ-030 Macro ALARM_SNOOZE_LIMIT_EN: when defined, snooze_button in RINGING with snooze_count == MAX_SNOOZE SHALL be ignored (ring continues to timeout/stop); when undefined, snoozes are unlimited up to snooze_count saturation and MAX_SNOOZE is unused.

Verification
REQ-031 alarm_time=16'h0730, current_time steps 16'h0729->16'h0730, alarm_enable=1 -> alarm_event pulse and sound_alarm=1 one clock after match; after 60 one_second ticks, sound_alarm=0, state DONE; current_time->16'h0731 -> IDLE.
REQ-032 Ringing, snooze_button one cycle -> snooze_active=1, snooze_count=1; after 120 ticks -> sound_alarm=1 with alarm_event pulse.
REQ-033 Ringing, stop_button and snooze_button same cycle -> DONE, snooze_count unchanged, no retrigger while current_time==alarm_time.
REQ-034 With ALARM_SNOOZE_LIMIT_EN, MAX_SNOOZE=3: fourth snooze press ignored, sound_alarm stays 1; without macro, fourth press -> snooze_count=4.
REQ-035 reset low during SNOOZE with match still true -> all outputs 0 immediately; after release, RINGING next cycle with alarm_event pulse.
REQ-036 alarm_enable dropped during RINGING -> sound_alarm=0 next cycle; re-enabled within same minute -> no retrigger.
